// File: rtl/transfer_engine.sv
// Two-party token ledger with a key-checked, fee-bearing transfer engine.
// Requests walk IDLE -> AUTH -> CHECK -> COMMIT -> RESP; failures short-circuit to RESP.
module transfer_engine #(
    parameter logic [7:0] FEE = 8'd0
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        load,
    input  logic [47:0] starting_memory,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_sender,
    input  logic [7:0]  req_key,
    input  logic [7:0]  req_amount,
    output logic        resp_valid,
    output logic [1:0]  resp_code,
    output logic [47:0] ledger
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_AUTH   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    localparam logic [1:0] CODE_OK     = 2'b00;
    localparam logic [1:0] CODE_BADKEY = 2'b01;
    localparam logic [1:0] CODE_INSUF  = 2'b10;
    localparam logic [1:0] CODE_REJECT = 2'b11;

    // Ledger byte lanes: p1 occupies [47:24], p2 occupies [23:0]; money is the low byte of each.
    function automatic logic [47:0] write_money(
        input logic [47:0] cur,
        input logic        sender,
        input logic [7:0]  sender_money,
        input logic [7:0]  receiver_money
    );
        logic [47:0] nxt;
        nxt = cur;
        if (sender == 1'b0) begin
            nxt[31:24] = sender_money;
            nxt[7:0]   = receiver_money;
        end else begin
            nxt[7:0]   = sender_money;
            nxt[31:24] = receiver_money;
        end
        return nxt;
    endfunction

    state_t      state_q, state_d;
    logic [47:0] ledger_q, ledger_d;
    logic        loaded_q, loaded_d;
    logic        resp_valid_q, resp_valid_d;
    logic [1:0]  resp_code_q, resp_code_d;
    logic        sender_q, sender_d;
    logic [7:0]  key_q, key_d;
    logic [7:0]  amount_q, amount_d;

    logic        ready_s;
    logic [7:0]  sender_priv_s;
    logic [7:0]  sender_money_s;
    logic [7:0]  receiver_money_s;
    logic [8:0]  debit_s;
    logic [8:0]  credit_s;

    assign ready_s   = (state_q == ST_IDLE) && !load && loaded_q;
    assign req_ready = ready_s;

    assign sender_priv_s    = sender_q ? ledger_q[23:16] : ledger_q[47:40];
    assign sender_money_s   = sender_q ? ledger_q[7:0]   : ledger_q[31:24];
    assign receiver_money_s = sender_q ? ledger_q[31:24] : ledger_q[7:0];

    // Nine-bit sums so the fee and the receiver overflow are visible in bit 8.
    assign debit_s  = {1'b0, amount_q} + {1'b0, FEE};
    assign credit_s = {1'b0, receiver_money_s} + {1'b0, amount_q};

    // Next-state, ledger and response-code logic.
    always_comb begin
        state_d     = state_q;
        ledger_d    = ledger_q;
        loaded_d    = loaded_q;
        resp_code_d = resp_code_q;
        sender_d    = sender_q;
        key_d       = key_q;
        amount_d    = amount_q;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    ledger_d = starting_memory;
                    loaded_d = 1'b1;
                end else if (req_valid && ready_s) begin
                    sender_d = req_sender;
                    key_d    = req_key;
                    amount_d = req_amount;
                    state_d  = ST_AUTH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_AUTH: begin
                if (key_q != sender_priv_s) begin
                    resp_code_d = CODE_BADKEY;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (amount_q == 8'd0) begin
                    resp_code_d = CODE_REJECT;
                    state_d     = ST_RESP;
                end else if (debit_s > {1'b0, sender_money_s}) begin
                    resp_code_d = CODE_INSUF;
                    state_d     = ST_RESP;
                end else if (credit_s[8]) begin
                    resp_code_d = CODE_REJECT;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                // CHECK guaranteed debit_s <= sender money, so the low byte is the exact difference.
                ledger_d    = write_money(ledger_q, sender_q,
                                          sender_money_s - debit_s[7:0],
                                          credit_s[7:0]);
                resp_code_d = CODE_OK;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        resp_valid_d = (state_d == ST_RESP);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            ledger_q     <= 48'h0;
            loaded_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_code_q  <= 2'b00;
            sender_q     <= 1'b0;
            key_q        <= 8'h00;
            amount_q     <= 8'h00;
        end else begin
            state_q      <= state_d;
            ledger_q     <= ledger_d;
            loaded_q     <= loaded_d;
            resp_valid_q <= resp_valid_d;
            resp_code_q  <= resp_code_d;
            sender_q     <= sender_d;
            key_q        <= key_d;
            amount_q     <= amount_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_code  = resp_code_q;
    assign ledger     = ledger_q;

endmodule

// File: tb/tb_transfer_engine.sv
// Directed self-checking bench for transfer_engine with FEE = 0.
module tb_transfer_engine;

    logic        clock;
    logic        resetn;
    logic        load;
    logic [47:0] starting_memory;
    logic        req_valid;
    logic        req_ready;
    logic        req_sender;
    logic [7:0]  req_key;
    logic [7:0]  req_amount;
    logic        resp_valid;
    logic [1:0]  resp_code;
    logic [47:0] ledger;

    int errors;
    int checks;

    localparam logic [47:0] MEM_A = 48'h75A1641BB264;
    localparam logic [47:0] MEM_B = 48'h75A1641BB2F0;

    transfer_engine #(.FEE(8'd0)) dut (
        .clock           (clock),
        .resetn          (resetn),
        .load            (load),
        .starting_memory (starting_memory),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_sender      (req_sender),
        .req_key         (req_key),
        .req_amount      (req_amount),
        .resp_valid      (resp_valid),
        .resp_code       (resp_code),
        .ledger          (ledger)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Called at a negedge; returns at a negedge.
    task automatic do_load(input logic [47:0] mem);
        load            = 1'b1;
        starting_memory = mem;
        @(posedge clock);
        #1 load = 1'b0;
        @(negedge clock);
    endtask

    // Issues one request; lat is the cycle offset k+lat of the pulse, or -1 when no pulse arrives.
    task automatic run_req(input logic s, input logic [7:0] k, input logic [7:0] a,
                           output int lat, output int width, output logic [1:0] code,
                           output logic [47:0] led, output logic rdy);
        req_sender = s;
        req_key    = k;
        req_amount = a;
        req_valid  = 1'b1;
        rdy        = req_ready;
        lat        = -1;
        width      = 0;
        code       = 2'bxx;
        led        = 48'hx;
        @(posedge clock);
        #1 req_valid = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            if (resp_valid === 1'b1) begin
                if (lat < 0) begin
                    lat  = n + 1;
                    code = resp_code;
                    led  = ledger;
                end
                width++;
            end else if (lat >= 0) begin
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (ledger !== 48'h0) begin errors++; $display("FAIL reset_ledger: got %h expected %h", ledger, 48'h0); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_code !== 2'b00) begin errors++; $display("FAIL reset_code: got %b expected 00", resp_code); end
        resetn = 1'b1;
        @(negedge clock);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    endtask

    task automatic test_load_gating();
        req_sender = 1'b0; req_key = 8'h75; req_amount = 8'h01;
        req_valid  = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL preload_ready[%0d]: got %b expected 0", n, req_ready); end
        end
        load = 1'b1;
        starting_memory = MEM_A;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL load_beats_req_ready: got %b expected 0", req_ready); end
        @(posedge clock);
        #1 load = 1'b0;
        checks++; if (ledger !== MEM_A) begin errors++; $display("FAIL gated_load_ledger: got %h expected %h", ledger, MEM_A); end
        @(negedge clock);
        // Still ready means the FSM stayed in IDLE across the load edge.
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_load: got %b expected 1", req_ready); end
        req_valid = 1'b0;
        @(negedge clock);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL no_resp_after_load: got %b expected 0", resp_valid); end
    endtask

    task automatic test_ok();
        int lat, width; logic [1:0] code; logic [47:0] led; logic rdy;
        run_req(1'b0, 8'h75, 8'h1E, lat, width, code, led, rdy);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL ok_ready: got %b expected 1", rdy); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL ok_latency: got %0d expected 4", lat); end
        checks++; if (width !== 1) begin errors++; $display("FAIL ok_pulse_width: got %0d expected 1", width); end
        checks++; if (code !== 2'b00) begin errors++; $display("FAIL ok_code: got %b expected 00", code); end
        checks++; if (led !== 48'h75A1461BB282) begin errors++; $display("FAIL ok_ledger_at_resp: got %h expected %h", led, 48'h75A1461BB282); end
        checks++; if (resp_code !== 2'b00) begin errors++; $display("FAIL ok_code_hold: got %b expected 00", resp_code); end
    endtask

    task automatic test_bad_key();
        int lat, width; logic [1:0] code; logic [47:0] led; logic rdy;
        do_load(MEM_A);
        run_req(1'b1, 8'h75, 8'h01, lat, width, code, led, rdy);
        checks++; if (lat !== 2) begin errors++; $display("FAIL badkey_latency: got %0d expected 2", lat); end
        checks++; if (code !== 2'b01) begin errors++; $display("FAIL badkey_code: got %b expected 01", code); end
        checks++; if (ledger !== MEM_A) begin errors++; $display("FAIL badkey_ledger: got %h expected %h", ledger, MEM_A); end
        checks++; if (resp_code !== 2'b01) begin errors++; $display("FAIL badkey_code_hold: got %b expected 01", resp_code); end
    endtask

    task automatic test_insufficient();
        int lat, width; logic [1:0] code; logic [47:0] led; logic rdy;
        run_req(1'b0, 8'h75, 8'h65, lat, width, code, led, rdy);
        checks++; if (lat !== 3) begin errors++; $display("FAIL insuf_latency: got %0d expected 3", lat); end
        checks++; if (code !== 2'b10) begin errors++; $display("FAIL insuf_code: got %b expected 10", code); end
        checks++; if (ledger !== MEM_A) begin errors++; $display("FAIL insuf_ledger: got %h expected %h", ledger, MEM_A); end
    endtask

    task automatic test_reject();
        int lat, width; logic [1:0] code; logic [47:0] led; logic rdy;
        do_load(MEM_B);
        run_req(1'b0, 8'h75, 8'h20, lat, width, code, led, rdy);
        checks++; if (lat !== 3) begin errors++; $display("FAIL overflow_latency: got %0d expected 3", lat); end
        checks++; if (code !== 2'b11) begin errors++; $display("FAIL overflow_code: got %b expected 11", code); end
        checks++; if (ledger !== MEM_B) begin errors++; $display("FAIL overflow_ledger: got %h expected %h", ledger, MEM_B); end
        run_req(1'b0, 8'h75, 8'h00, lat, width, code, led, rdy);
        checks++; if (lat !== 3) begin errors++; $display("FAIL zero_latency: got %0d expected 3", lat); end
        checks++; if (code !== 2'b11) begin errors++; $display("FAIL zero_code: got %b expected 11", code); end
        checks++; if (ledger !== MEM_B) begin errors++; $display("FAIL zero_ledger: got %h expected %h", ledger, MEM_B); end
    endtask

    task automatic test_boundary();
        int lat, width; logic [1:0] code; logic [47:0] led; logic rdy;
        do_load(MEM_A);
        // Sender spends its whole balance exactly.
        run_req(1'b0, 8'h75, 8'h64, lat, width, code, led, rdy);
        checks++; if (code !== 2'b00) begin errors++; $display("FAIL exact_code: got %b expected 00", code); end
        checks++; if (led !== 48'h75A1001BB2C8) begin errors++; $display("FAIL exact_ledger: got %h expected %h", led, 48'h75A1001BB2C8); end
        run_req(1'b0, 8'h75, 8'h01, lat, width, code, led, rdy);
        checks++; if (lat !== 3) begin errors++; $display("FAIL empty_latency: got %0d expected 3", lat); end
        checks++; if (code !== 2'b10) begin errors++; $display("FAIL empty_code: got %b expected 10", code); end
    endtask

    task automatic test_back_to_back();
        int lat, width; logic [1:0] code; logic [47:0] led; logic rdy;
        do_load(MEM_A);
        run_req(1'b0, 8'h75, 8'h01, lat, width, code, led, rdy);
        checks++; if (led !== 48'h75A1631BB265) begin errors++; $display("FAIL b2b_first_ledger: got %h expected %h", led, 48'h75A1631BB265); end
        run_req(1'b1, 8'h1B, 8'h02, lat, width, code, led, rdy);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_resp: got %b expected 1", rdy); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 4", lat); end
        checks++; if (code !== 2'b00) begin errors++; $display("FAIL b2b_second_code: got %b expected 00", code); end
        checks++; if (led !== 48'h75A1651BB263) begin errors++; $display("FAIL b2b_second_ledger: got %h expected %h", led, 48'h75A1651BB263); end
    endtask

    task automatic test_load_busy();
        do_load(MEM_A);
        req_sender = 1'b0; req_key = 8'h75; req_amount = 8'h0A;
        req_valid  = 1'b1;
        @(posedge clock);
        for (int n = 0; n < 4; n++) begin
            @(negedge clock);
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL busy_ready[%0d]: got %b expected 0", n, req_ready); end
            if (n == 0) begin
                load = 1'b1;
                starting_memory = 48'hFFFFFFFFFFFF;
            end else begin
                load = 1'b0;
            end
        end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL busy_resp_valid: got %b expected 1", resp_valid); end
        checks++; if (ledger !== 48'h75A15A1BB26E) begin errors++; $display("FAIL busy_load_ignored: got %h expected %h", ledger, 48'h75A15A1BB26E); end
        @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL busy_ready_idle: got %b expected 1", req_ready); end
        req_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid_commit();
        int seen;
        do_load(MEM_A);
        req_sender = 1'b0; req_key = 8'h75; req_amount = 8'h1E;
        req_valid  = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b0;
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        checks++; if (ledger !== 48'h0) begin errors++; $display("FAIL midreset_ledger: got %h expected %h", ledger, 48'h0); end
        seen = (resp_valid === 1'b1) ? 1 : 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            if (resp_valid === 1'b1) seen++;
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready[%0d]: got %b expected 0", n, req_ready); end
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_pulse: got %0d pulses expected 0", seen); end
        checks++; if (ledger !== 48'h0) begin errors++; $display("FAIL midreset_ledger_hold: got %h expected %h", ledger, 48'h0); end
        do_load(MEM_A);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready_after_load: got %b expected 1", req_ready); end
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        resetn          = 1'b0;
        load            = 1'b0;
        starting_memory = 48'h0;
        req_valid       = 1'b0;
        req_sender      = 1'b0;
        req_key         = 8'h00;
        req_amount      = 8'h00;
        @(negedge clock);
        test_reset();
        test_load_gating();
        test_ok();
        test_bad_key();
        test_insufficient();
        test_reject();
        test_boundary();
        test_back_to_back();
        test_load_busy();
        test_reset_mid_commit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/transfer_engine.md
TRANSFER_ENGINE -- requirements
Module: transfer_engine

Interface
REQ-001 Parameter FEE, default 0: 8-bit amount burned from the sender on each successful transfer, in addition to the transferred amount.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 load  input  1  when high, copies starting_memory into the ledger.
REQ-005 starting_memory  input  48  {p1_private, p1_public, p1_money, p2_private, p2_public, p2_money}, 8 bits each, MSB first.
REQ-006 req_valid  input  1  transfer request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_sender  input  1  0 = p1 pays p2; 1 = p2 pays p1.
REQ-009 req_key  input  8  private key claimed by the sender.
REQ-010 req_amount  input  8  unsigned amount to transfer.
REQ-011 resp_valid  output  1  one-cycle pulse carrying the result.
REQ-012 resp_code  output  2  result code: 00 OK, 01 BAD_KEY, 10 INSUFFICIENT, 11 REJECT (overflow or zero amount).
REQ-013 ledger  output  48  current ledger, same packing as starting_memory.

Function
REQ-014 The FSM SHALL have the states IDLE, AUTH, CHECK, COMMIT and RESP, each lasting exactly one cycle except IDLE.
REQ-015 req_ready SHALL be high only in IDLE, with load low and the loaded flag set; it is combinational from these signals.
REQ-016 A request SHALL be accepted on an edge where req_valid and req_ready are both high; req_sender, req_key and req_amount are captured at that edge.
REQ-017 After acceptance the FSM SHALL move to AUTH; request inputs are ignored until the FSM returns to IDLE.
REQ-018 AUTH SHALL compare the captured key with the sender's stored private byte.
  - Mismatch: go to RESP with code 01.
  - Match: go to CHECK.
REQ-019 CHECK SHALL evaluate, in 9-bit arithmetic, in this priority order:
  - amount = 0: go to RESP with code 11.
  - amount + FEE > sender_money: go to RESP with code 10.
  - receiver_money + amount > 255: go to RESP with code 11.
  - None of the above: go to COMMIT.
REQ-020 COMMIT SHALL update the ledger at its exit edge, then go to RESP with code 00.
  - sender_money -= amount + FEE.
  - receiver_money += amount.
  - The ledger is updated atomically, and private and public bytes are never modified.
REQ-021 RESP SHALL drive resp_valid high for exactly one cycle with the final resp_code, then return to IDLE.
REQ-022 With acceptance at edge k, resp_valid SHALL be high in these cycles:
  - Cycle k+2 for BAD_KEY.
  - Cycle k+3 for INSUFFICIENT or REJECT.
  - Cycle k+4 for OK, with the updated ledger already visible in that cycle.
REQ-023 resp_code SHALL hold its last value while resp_valid is low.
REQ-024 load high in IDLE SHALL copy starting_memory into ledger at that edge and set the loaded flag.
REQ-025 load asserted outside IDLE SHALL be ignored.
REQ-026 load and req_valid high together in IDLE: load SHALL win and the request SHALL NOT be accepted that cycle.
REQ-027 Before the first load after reset, req_ready SHALL stay low.
REQ-028 Back-to-back requests SHALL be accepted no earlier than the cycle after RESP.

Reset
REQ-029 When resetn is low at an edge, the block SHALL apply these values:
  - state = IDLE.
  - ledger = 48'h0.
  - loaded flag = 0.
  - resp_valid = 0.
  - resp_code = 00.
  - Captured request registers = 0.
REQ-030 Reset SHALL take precedence over load and over requests in any state.
REQ-031 Reset in any state, including COMMIT, SHALL abandon the transfer with no partial ledger update surviving and no response pulse.

Verification
REQ-032 Successful transfer: FEE=0, reset, load 48'h75A1641BB264, then request sender=0, key=0x75, amount=0x1E accepted at edge k.
  - Required response: resp_valid high in cycle k+4 with code 00.
  - Required ledger: 48'h75A1461BB282.
REQ-033 Bad key: from the REQ-032 load, request sender=1, key=0x75, amount=1.
  - Required response: code 01 in cycle k+2.
  - Required ledger: unchanged.
REQ-034 Insufficient funds: from the REQ-032 load, request sender=0, key=0x75, amount=0x65.
  - Required response: code 10 in cycle k+3.
  - Required ledger: unchanged.
REQ-035 Receiver overflow and zero amount: load 48'h75A1641BB2F0.
  - Request sender=0, key=0x75, amount=0x20: code 11 in cycle k+3, ledger unchanged.
  - Request with amount=0: code 11 in cycle k+3, ledger unchanged.
REQ-036 Load gating: before any load, req_valid held high -> req_ready stays low. Then load and req_valid high in the same cycle -> ledger loads and no request is accepted that cycle; req_ready rises the next cycle.
REQ-037 Reset mid-operation: resetn driven low during COMMIT of the REQ-032 request.
  - Required ledger: 48'h0, with no resp_valid pulse.
  - Required flags: loaded flag cleared and req_ready low until the next load.
